cdb_arbiter: RTL

- Completion-side counterpart of the reservation station. Collects finished results from the functional units and serialises them onto the single-wide CDB, one per cycle.
- For each winner, drives the CDB tag broadcast (wakeup of waiting RS operands), the RS-entry release (remove), and the ROB complete strobe.
- Sits between the execute units and the RS/ROB/map table. Each FU has a one-entry holding buffer with valid/ready backpressure.

---
 rtl/cdb_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Completion-side CDB arbiter: one holding buffer per FU, round-robin pick,
// single-wide broadcast of tag wakeup, RS release and ROB complete.
module cdb_arbiter #(
   parameter int NUM_FU    = 5,
   parameter int PREG_W    = 6,
   parameter int RS_IDX_W  = 3,
   parameter int ROB_IDX_W = 5
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          squash,
   input  logic [NUM_FU-1:0]             fu_valid,
   output logic [NUM_FU-1:0]             fu_ready,
   input  logic [NUM_FU-1:0]             fu_has_dest,
   input  logic [NUM_FU*PREG_W-1:0]      fu_preg,
   input  logic [NUM_FU*RS_IDX_W-1:0]    fu_rs_idx,
   input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_idx,
   output logic                          cdb_en,
   output logic [PREG_W-1:0]             cdb_preg,
   output logic                          rs_remove_en,
   output logic [RS_IDX_W-1:0]           rs_remove_idx,
   output logic                          rob_complete_en,
   output logic [ROB_IDX_W-1:0]          rob_complete_idx
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0]    buf_valid;
   logic                 buf_has_dest [NUM_FU];
   logic [PREG_W-1:0]    buf_preg     [NUM_FU];
   logic [RS_IDX_W-1:0]  buf_rs_idx   [NUM_FU];
   logic [ROB_IDX_W-1:0] buf_rob_idx  [NUM_FU];

   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     win_idx;
   logic [PTR_W-1:0]     next_ptr;
   logic                 found;
   logic                 any_grant;
   logic [NUM_FU-1:0]    grant;
   int                   scan_idx;

   // Round-robin scan starting at rr_ptr; only registered state feeds the pick.
   always_comb begin
      found    = 1'b0;
      win_idx  = '0;
      scan_idx = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NUM_FU) scan_idx = scan_idx - NUM_FU;
         if (!found && buf_valid[PTR_W'(scan_idx)]) begin
            found   = 1'b1;
            win_idx = PTR_W'(scan_idx);
         end
      end
      any_grant = found && !reset && !squash;
      grant     = '0;
      if (any_grant) grant[win_idx] = 1'b1;
      next_ptr  = (win_idx == PTR_W'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;
   end

   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         fu_ready[i] = !reset && !squash && (!buf_valid[i] || grant[i]);
      end
   end

   assign rs_remove_en     = any_grant;
   assign rob_complete_en  = any_grant;
   assign rs_remove_idx    = any_grant ? buf_rs_idx[win_idx]  : '0;
   assign rob_complete_idx = any_grant ? buf_rob_idx[win_idx] : '0;
   assign cdb_en           = any_grant && buf_has_dest[win_idx];
   assign cdb_preg         = cdb_en ? buf_preg[win_idx] : '0;

   // A granted buffer may refill on the same edge it drains.
   always_ff @(posedge clock) begin
      if (reset || squash) begin
         buf_valid <= '0;
         rr_ptr    <= '0;
      end else begin
         if (any_grant) rr_ptr <= next_ptr;
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
               buf_valid[i]    <= 1'b1;
               buf_has_dest[i] <= fu_has_dest[i];
               buf_preg[i]     <= fu_preg[i*PREG_W +: PREG_W];
               buf_rs_idx[i]   <= fu_rs_idx[i*RS_IDX_W +: RS_IDX_W];
               buf_rob_idx[i]  <= fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            end else if (grant[i]) begin
               buf_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule
